// File: rtl/risc16_pkg.sv
// RiSC-16 shared encoding constants: opcodes, field positions, immediate limits,
// instruction formats and encoder error codes.
package risc16_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam int OP_LSB = 13;
  localparam int RA_LSB = 10;
  localparam int RB_LSB = 7;

  localparam logic signed [15:0] IMM7_MIN  = -16'sd64;
  localparam logic signed [15:0] IMM7_MAX  = 16'sd63;
  localparam logic        [15:0] IMM10_MAX = 16'd1023;

  typedef enum logic [1:0] {FMT_RRR, FMT_RRI, FMT_RI} fmt_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_RANGE    = 2'b01;
  localparam logic [1:0] ERR_JALR_IMM = 2'b10;

  function automatic fmt_e fmt_of(input logic [2:0] op);
    case (op)
      OP_ADD, OP_NAND:                     fmt_of = FMT_RRR;
      OP_LUI:                              fmt_of = FMT_RI;
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JALR: fmt_of = FMT_RRI;
      default:                             fmt_of = FMT_RRR;
    endcase
  endfunction

endpackage

// File: rtl/risc16_insn_encoder_if.sv
// Field-in / memory-write-out bus of the RiSC-16 instruction encoder.
interface risc16_insn_encoder_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic              in_movi;
  logic [2:0]        in_ra;
  logic [2:0]        in_rb;
  logic [2:0]        in_rc;
  logic [15:0]       in_imm;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_in;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              err_valid;
  logic [1:0]        err_code;
  logic              err_sticky;
  logic              wrapped;

  modport master (
    output in_valid, in_op, in_movi, in_ra, in_rb, in_rc, in_imm, addr_load, addr_in,
    input  in_ready, imem_we, imem_addr, imem_wdata, err_valid, err_code, err_sticky, wrapped
  );

  modport slave (
    input  in_valid, in_op, in_movi, in_ra, in_rb, in_rc, in_imm, addr_load, addr_in,
    output in_ready, imem_we, imem_addr, imem_wdata, err_valid, err_code, err_sticky, wrapped
  );
endinterface

// File: rtl/risc16_field_pack.sv
// Combinational packer: symbolic fields -> 16-bit RiSC-16 word plus range flags.
module risc16_field_pack
  import risc16_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [2:0]  ra,
  input  logic [2:0]  rb,
  input  logic [2:0]  rc,
  input  logic [15:0] imm,
  output logic [15:0] word,
  output fmt_e        fmt,
  output logic        range_ok,
  output logic        jalr_ok
);

  always_comb begin
    fmt                  = fmt_of(op);
    word                 = '0;
    word[OP_LSB +: 3]    = op;
    word[RA_LSB +: 3]    = ra;
    range_ok             = 1'b1;
    jalr_ok              = 1'b1;
    case (fmt)
      FMT_RRR: begin
        word[RB_LSB +: 3] = rb;
        word[2:0]         = rc;
      end
      FMT_RRI: begin
        word[RB_LSB +: 3] = rb;
        word[6:0]         = imm[6:0];
        range_ok          = ($signed(imm) >= IMM7_MIN) && ($signed(imm) <= IMM7_MAX);
      end
      FMT_RI: begin
        word[9:0] = imm[9:0];
        range_ok  = (imm <= IMM10_MAX);
      end
      default: ;
    endcase
    // JALR is RRI-shaped but only a zero offset is meaningful.
    if (op == OP_JALR) jalr_ok = (imm == 16'd0);
  end

endmodule

// File: rtl/risc16_insn_encoder.sv
// RiSC-16 instruction encoder/loader: packs fields, expands MOVI into LUI+ADDI,
// and writes words to sequential instruction-memory addresses.
module risc16_insn_encoder
  import risc16_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  risc16_insn_encoder_if.slave bus
);

  typedef enum logic {S_IDLE, S_MOVI2} state_e;

  state_e            state, state_nx;
  logic [ADDR_W-1:0] waddr;
  logic [2:0]        mv_ra;
  logic [5:0]        mv_lo;

  logic [2:0]  p_op, p_ra, p_rb, p_rc;
  logic [15:0] p_imm, p_word;
  fmt_e        p_fmt;
  logic        p_range_ok, p_jalr_ok;
  logic        accept, do_wr, do_err;
  logic [1:0]  err_nx;

  risc16_field_pack u_pack (
    .op(p_op), .ra(p_ra), .rb(p_rb), .rc(p_rc), .imm(p_imm),
    .word(p_word), .fmt(p_fmt), .range_ok(p_range_ok), .jalr_ok(p_jalr_ok)
  );

  always_comb begin
    state_nx     = state;
    bus.in_ready = 1'b0;
    accept       = 1'b0;
    do_wr        = 1'b0;
    do_err       = 1'b0;
    err_nx       = ERR_NONE;
    p_op         = bus.in_op;
    p_ra         = bus.in_ra;
    p_rb         = bus.in_rb;
    p_rc         = bus.in_rc;
    p_imm        = bus.in_imm;
    case (state)
      S_IDLE: begin
        bus.in_ready = !bus.addr_load;
        accept       = bus.in_valid && !bus.addr_load;
        // MOVI first word is LUI of the upper ten immediate bits.
        if (bus.in_movi) begin
          p_op  = OP_LUI;
          p_imm = {6'd0, bus.in_imm[15:6]};
        end
        if (accept) begin
          if (bus.in_movi) begin
            do_wr    = 1'b1;
            state_nx = S_MOVI2;
          end else if (!p_jalr_ok) begin
            do_err = 1'b1;
            err_nx = ERR_JALR_IMM;
          end else if ((p_fmt != FMT_RRR) && !p_range_ok) begin
            do_err = 1'b1;
            err_nx = ERR_RANGE;
          end else begin
            do_wr = 1'b1;
          end
        end
      end
      S_MOVI2: begin
        p_op     = OP_ADDI;
        p_ra     = mv_ra;
        p_rb     = mv_ra;
        p_rc     = 3'd0;
        p_imm    = {10'd0, mv_lo};
        do_wr    = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr          <= '0;
      mv_ra          <= '0;
      mv_lo          <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.err_valid  <= 1'b0;
      bus.err_code   <= ERR_NONE;
      bus.err_sticky <= 1'b0;
      bus.wrapped    <= 1'b0;
    end else begin
      bus.imem_we   <= do_wr;
      bus.err_valid <= do_err;
      if (do_wr) begin
        bus.imem_addr  <= waddr;
        bus.imem_wdata <= p_word;
        waddr          <= waddr + 1'b1;
        if (&waddr) bus.wrapped <= 1'b1;
      end
      // A pending load overrides the post-write increment.
      if (bus.addr_load) waddr <= bus.addr_in;
      if (do_err) begin
        bus.err_code   <= err_nx;
        bus.err_sticky <= 1'b1;
      end
      if (accept && bus.in_movi) begin
        mv_ra <= bus.in_ra;
        mv_lo <= bus.in_imm[5:0];
      end
    end
  end

endmodule

// File: tb/tb_risc16_insn_encoder.sv
// Randomized + directed bench for risc16_insn_encoder against a word-level model.
module tb_risc16_insn_encoder;
  import risc16_pkg::*;

  localparam int AW   = 4;
  localparam int AMAX = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  int   maddr = 0;
  bit   mwrap = 0;
  int   mcode = 0;
  bit   msticky = 0;

  risc16_insn_encoder_if #(.ADDR_W(AW)) bus ();

  risc16_insn_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_we"},    32'(bus.imem_we), 0);
    chk({tag, "_addr"},  32'(bus.imem_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.imem_wdata), 0);
    chk({tag, "_errv"},  32'(bus.err_valid), 0);
    chk({tag, "_errc"},  32'(bus.err_code), 0);
    chk({tag, "_stky"},  32'(bus.err_sticky), 0);
    chk({tag, "_wrap"},  32'(bus.wrapped), 0);
  endtask

  function automatic void model_reset();
    maddr = 0; mwrap = 0; mcode = 0; msticky = 0;
  endfunction

  function automatic void adv();
    if (maddr == AMAX) begin maddr = 0; mwrap = 1; end
    else maddr++;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge following the last word.
  task automatic issue(input bit movi, input logic [2:0] op, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] rc, input logic [15:0] imm);
    int simm, uimm, code, w1, w2, o, a, b;
    simm = int'($signed(imm));
    uimm = int'(imm);
    o = int'(op); a = int'(ra); b = int'(rb);
    code = 0;
    if (movi) begin
      w1 = 3 * 8192 + a * 1024 + uimm / 64;
      w2 = 1 * 8192 + a * 1024 + a * 128 + uimm % 64;
    end else begin
      w2 = 0;
      case (o)
        0, 2: w1 = o * 8192 + a * 1024 + b * 128 + int'(rc);
        3: begin
          w1 = o * 8192 + a * 1024 + uimm % 1024;
          if (uimm > 1023) code = 1;
        end
        7: begin
          w1 = o * 8192 + a * 1024 + b * 128 + (simm & 127);
          if (uimm != 0) code = 2;
        end
        default: begin
          w1 = o * 8192 + a * 1024 + b * 128 + (simm & 127);
          if (simm < -64 || simm > 63) code = 1;
        end
      endcase
    end
    bus.in_valid = 1'b1; bus.in_movi = movi; bus.in_op = op;
    bus.in_ra = ra; bus.in_rb = rb; bus.in_rc = rc; bus.in_imm = imm;
    #1 chk("ready_pre", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (code != 0) begin
      mcode = code; msticky = 1;
      chk("err_we",    32'(bus.imem_we), 0);
      chk("err_valid", 32'(bus.err_valid), 1);
      chk("err_code",  32'(bus.err_code), 32'(code));
      chk("err_stky",  32'(bus.err_sticky), 1);
    end else begin
      chk("w1_we",    32'(bus.imem_we), 1);
      chk("w1_addr",  32'(bus.imem_addr), 32'(maddr));
      chk("w1_wdata", 32'(bus.imem_wdata), 32'(w1));
      chk("w1_errv",  32'(bus.err_valid), 0);
      chk("w1_errc",  32'(bus.err_code), 32'(mcode));
      chk("w1_stky",  32'(bus.err_sticky), 32'(msticky));
      adv();
    end
    if (movi) begin
      chk("movi_busy", 32'(bus.in_ready), 0);
      @(posedge clk); #1;
      chk("w2_we",    32'(bus.imem_we), 1);
      chk("w2_addr",  32'(bus.imem_addr), 32'(maddr));
      chk("w2_wdata", 32'(bus.imem_wdata), 32'(w2));
      chk("w2_ready", 32'(bus.in_ready), 1);
      adv();
    end
    chk("wrapped", 32'(bus.wrapped), 32'(mwrap));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #3 chk_reset("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] imm;
    bus.in_valid = 1'b0; bus.in_movi = 1'b0; bus.in_op = '0; bus.in_ra = '0;
    bus.in_rb = '0; bus.in_rc = '0; bus.in_imm = '0; bus.addr_load = 1'b0; bus.addr_in = '0;
    #2 do_reset();

    // Directed encodings and range boundaries.
    issue(0, OP_ADD,  3'd1, 3'd2, 3'd3, 16'h0000);
    chk("add_lit", 32'(bus.imem_wdata), 32'h0503);
    issue(0, OP_ADDI, 3'd1, 3'd1, 3'd0, 16'hFFFF);
    chk("addi_lit", 32'(bus.imem_wdata), 32'h24FF);
    issue(0, OP_ADDI, 3'd1, 3'd1, 3'd0, 16'd64);
    issue(0, OP_NAND, 3'd0, 3'd5, 3'd6, 16'h1234);
    issue(0, OP_JALR, 3'd7, 3'd1, 3'd0, 16'd1);
    issue(0, OP_JALR, 3'd7, 3'd1, 3'd0, 16'd0);
    chk("jalr_lit", 32'(bus.imem_wdata), 32'hFC80);
    issue(0, OP_LUI,  3'd3, 3'd0, 3'd0, 16'd1023);
    issue(0, OP_LUI,  3'd3, 3'd0, 3'd0, 16'd1024);
    issue(0, OP_BEQ,  3'd2, 3'd4, 3'd0, 16'hFFC0);
    issue(0, OP_SW,   3'd2, 3'd4, 3'd0, 16'd63);
    issue(0, OP_LW,   3'd2, 3'd4, 3'd0, 16'hFFBF);

    do_reset();
    issue(1, OP_ADD, 3'd2, 3'd0, 3'd0, 16'hABCD);
    chk("movi2_lit", 32'(bus.imem_wdata), 32'h290D);

    // Address load blocks acceptance, then writes wrap 15 -> 0.
    bus.addr_load = 1'b1; bus.addr_in = 4'd15; bus.in_valid = 1'b1;
    bus.in_movi = 1'b0; bus.in_op = OP_ADD;
    #1 chk("ld_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("ld_noacc", 32'(bus.imem_we), 0);
    bus.addr_load = 1'b0; bus.in_valid = 1'b0;
    maddr = 15;
    issue(0, OP_ADD, 3'd1, 3'd1, 3'd1, 16'd0);
    issue(0, OP_ADD, 3'd2, 3'd2, 3'd2, 16'd0);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: imm = 16'($urandom_range(0, 140)) - 16'd70;
        1: imm = 16'($urandom_range(0, 1100));
        2: imm = 16'd0;
        default: imm = 16'($urandom);
      endcase
      issue($urandom_range(0, 7) == 0, 3'($urandom), 3'($urandom), 3'($urandom),
            3'($urandom), imm);
    end

    // Reset during the MOVI second cycle aborts the ADDI.
    bus.in_valid = 1'b1; bus.in_movi = 1'b1; bus.in_ra = 3'd4; bus.in_imm = 16'h1234;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_movi = 1'b0;
    chk("ab_w1", 32'(bus.imem_we), 1);
    rst_n = 1'b0;
    model_reset();
    #1 chk_reset("ab");
    @(posedge clk); #1;
    chk_reset("ab_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ab_now2", 32'(bus.imem_we), 0);
    issue(0, OP_ADD, 3'd1, 3'd2, 3'd3, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/risc16_insn_encoder.md
# risc16_insn_encoder

Instruction encoder and loader for the RiSC-16 core: accepts symbolic instruction fields over a valid/ready handshake, packs them into 16-bit RiSC-16 words, and writes them sequentially into instruction memory. It is the encode-side counterpart of the core's opcode decode and is used by the boot/debug path to load programs. It also expands a MOVI pseudo-instruction into an LUI/ADDI pair, with range checking and error reporting.

## Interface
- ADDR_W, default 8: instruction-memory address width.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  encoder can accept this cycle.
- in_op  input  3  opcode (000 ADD, 001 ADDI, 010 NAND, 011 LUI, 100 LW, 101 SW, 110 BEQ, 111 JALR).
- in_movi  input  1  when 1, in_op is ignored and MOVI rA,imm16 is encoded.
- in_ra, in_rb, in_rc  input  3 each  register fields.
- in_imm  input  16  immediate, two's complement (unsigned for LUI/MOVI).
- addr_load  input  1  load write address from addr_in.
- addr_in  input  ADDR_W  new write address.
- imem_we  output  1  one-cycle write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  16  encoded word.
- err_valid  output  1  one-cycle pulse on rejected instruction.
- err_code  output  2  01 RANGE, 10 JALR_IMM; held until next error.
- err_sticky  output  1  set on any error, cleared only by reset.
- wrapped  output  1  sticky; set when the address wraps from all-ones to 0.

## Operation
- Word layout: [15:13] op, [12:10] rA, [9:7] rB; RRR (ADD, NAND): [6:3]=0, [2:0]=rC; RRI (ADDI, LW, SW, BEQ, JALR): [6:0]=imm7; RI (LUI): [9:0]=imm10.
- Range rules: RRI imm must be in -64..63; LUI imm must be 0..1023 (in_imm[15:10]==0); JALR imm must be 0 (else JALR_IMM). RRR ignores in_imm. Violation -> no write, err_valid=1, err_code set, address unchanged.
- MOVI rA,imm16: word 1 = LUI rA, imm[15:6]; word 2 = ADDI rA,rA, {0,imm[5:0]}. Always in range.
- rA=0 is legal; no error.
- FSM: IDLE (in_ready=1 unless addr_load=1) -> on accepted MOVI -> MOVI2 (in_ready=0, emits ADDI) -> IDLE.
- Address: increments by 1 after each write, wraps modulo 2^ADDR_W; wrap sets wrapped.
- addr_load takes priority: while it is 1, in_ready=0 and no fields are accepted. The load takes effect on the next edge.

## Timing
- Reset values: in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, err_valid=0, err_code=00, err_sticky=0, wrapped=0, FSM=IDLE.
- Outputs are registered. A transfer accepted at edge N drives imem_we/addr/wdata during cycle N+1.
- MOVI writes word 1 in cycle N+1 and word 2 in cycle N+2, at consecutive addresses. in_ready is 0 during cycle N+1, so the next accept is no earlier than edge N+2. Sustained throughput for non-MOVI is one instruction per cycle.
- err_valid follows the same one-cycle latency as a write. Error and write are mutually exclusive.
- Reset asserted mid-MOVI aborts the sequence: the second word is never written.

## Structure
- risc16_pkg holds opcode constants, field bit positions, imm range limits, the format enum (RRR/RRI/RI), and the err_code constants. The control decoder shares the opcode constants.
- One combinational sub-module, risc16_field_pack: op, fields, and imm in; word, format, and range-ok flags out. The FSM, address counter, and error logic live in the top.

## Test plan
- ADD r1,r2,r3 at addr 0 -> imem_we at cycle 1, addr 0, wdata 16'h0503.
- ADDI r1,r1,-1 -> wdata 16'h24FF; then ADDI imm=64 -> no write, err_valid pulse, err_code=01, err_sticky=1, next write still at addr 1.
- MOVI r2,16'hABCD at addr 0 -> 16'h6AAF at addr 0, then 16'h290D at addr 1; in_ready=0 for exactly one cycle.
- JALR r7,r1 with imm=1 -> err_code=10, no write. With imm=0 -> wdata 16'hFC80.
- ADDR_W=4: addr_load 15, then two ADDs -> writes at 15 then 0; wrapped=1. addr_load held with in_valid=1 -> in_ready=0, nothing accepted.
- Assert rst_n low in the MOVI second cycle -> no ADDI written; all outputs at reset values while rst_n=0.
